// File: rtl/immediate_decode_stage.sv
// Registered immediate-generation stage: decodes the RV immediate, format code and illegal flag
// from one instruction per cycle, with an optional 2-entry skid buffer on the output side.
module immediate_decode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instruction,
  output logic [XLEN-1:0] out_immediate,
  output logic [2:0]      out_format,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high; once
  // out_valid is raised, every out_* stays stable until out_ready is seen high with it.
  logic            in_fire;
  logic            out_fire;
  logic            out_free;

  logic [XLEN-1:0] dec_immediate;
  logic [2:0]      dec_format;
  logic            dec_illegal;

  logic            skid_valid;
  logic [31:0]     skid_instruction;
  logic [XLEN-1:0] skid_immediate;
  logic [2:0]      skid_format;
  logic            skid_illegal;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_free = out_fire | ~out_valid;

  if (SKID != 0) begin : g_skid
    assign in_ready = ~skid_valid;
  end else begin : g_single
    assign in_ready = out_ready | ~out_valid;
  end

  // Sign extension fills the whole word with bit 31 first, then overwrites the low field.
  always_comb begin
    dec_immediate = '0;
    dec_format    = FMT_NONE;
    dec_illegal   = 1'b0;
    if (in_instruction[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (in_instruction[6:0])
        7'b0000011, 7'b0010011, 7'b1100111: begin
          dec_format          = FMT_I;
          dec_immediate       = {XLEN{in_instruction[31]}};
          dec_immediate[11:0] = in_instruction[31:20];
        end
        7'b1110011: begin
          if (in_instruction[14]) begin
            dec_format         = FMT_Z;
            dec_immediate[4:0] = in_instruction[19:15];
          end else begin
            dec_format          = FMT_I;
            dec_immediate       = {XLEN{in_instruction[31]}};
            dec_immediate[11:0] = in_instruction[31:20];
          end
        end
        7'b0100011: begin
          dec_format          = FMT_S;
          dec_immediate       = {XLEN{in_instruction[31]}};
          dec_immediate[11:0] = {in_instruction[31:25], in_instruction[11:7]};
        end
        7'b1100011: begin
          dec_format          = FMT_B;
          dec_immediate       = {XLEN{in_instruction[31]}};
          dec_immediate[12:0] = {in_instruction[31], in_instruction[7], in_instruction[30:25],
                                 in_instruction[11:8], 1'b0};
        end
        7'b1101111: begin
          dec_format          = FMT_J;
          dec_immediate       = {XLEN{in_instruction[31]}};
          dec_immediate[20:0] = {in_instruction[31], in_instruction[19:12], in_instruction[20],
                                 in_instruction[30:21], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          dec_format          = FMT_U;
          dec_immediate       = {XLEN{in_instruction[31]}};
          dec_immediate[31:0] = {in_instruction[31:12], 12'b0};
        end
        7'b0110011, 7'b0001111: begin
          dec_format = FMT_NONE;
        end
        default: begin
          dec_illegal = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid        <= 1'b0;
      out_instruction  <= '0;
      out_immediate    <= '0;
      out_format       <= '0;
      out_illegal      <= 1'b0;
      skid_valid       <= 1'b0;
      skid_instruction <= '0;
      skid_immediate   <= '0;
      skid_format      <= '0;
      skid_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      // The skid entry is older than anything arriving now, so it drains first.
      if (skid_valid) begin
        out_valid       <= 1'b1;
        out_instruction <= skid_instruction;
        out_immediate   <= skid_immediate;
        out_format      <= skid_format;
        out_illegal     <= skid_illegal;
        skid_valid      <= 1'b0;
      end else if (in_fire) begin
        out_valid       <= 1'b1;
        out_instruction <= in_instruction;
        out_immediate   <= dec_immediate;
        out_format      <= dec_format;
        out_illegal     <= dec_illegal;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire && SKID != 0) begin
      skid_valid       <= 1'b1;
      skid_instruction <= in_instruction;
      skid_immediate   <= dec_immediate;
      skid_format      <= dec_format;
      skid_illegal     <= dec_illegal;
    end
  end

endmodule
